// File: rtl/adder_flag_register.sv
// Registered output stage for adderWithStatusFlags: holds Z and {S,ZR,CY,P,V} behind a
// valid/ready handshake, tracks sticky carry/overflow, counts overflows and evaluates condition codes.
module adder_flag_register #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_s,
    input  logic             in_zr,
    input  logic             in_cy,
    input  logic             in_p,
    input  logic             in_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic [4:0]       out_flags,
    output logic             flag_err,
    input  logic [3:0]       cond_sel,
    output logic             cond_true,
    input  logic             clr_sticky,
    output logic             sticky_cy,
    output logic             sticky_v,
    output logic [CNT_W-1:0] ovf_count
);

    // Handshake: a beat moves when in_valid & in_ready. in_ready is high whenever the
    // output register is empty or is being drained this cycle; there is no skid buffer.

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [4:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic             sticky_cy_q, sticky_cy_d;
    logic             sticky_v_q, sticky_v_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    logic accept;
    logic in_err;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Parity flag is odd parity: 1 when Z holds an odd number of ones.
    assign in_err = (in_s != in_z[WIDTH-1]) ||
                    (in_zr != (in_z == '0)) ||
                    (in_p != ^in_z);

    always_comb begin
        out_valid_d = out_valid_q;
        z_d         = z_q;
        flags_d     = flags_q;
        err_d       = err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            z_d         = in_z;
            flags_d     = {in_s, in_zr, in_cy, in_p, in_v};
            err_d       = in_err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // A clear that coincides with an accepted beat restarts from that beat's events.
    always_comb begin
        sticky_cy_d = sticky_cy_q;
        sticky_v_d  = sticky_v_q;
        ovf_count_d = ovf_count_q;
        if (clr_sticky && accept) begin
            sticky_cy_d = in_cy;
            sticky_v_d  = in_v;
            ovf_count_d = CNT_W'(in_v);
        end else if (clr_sticky) begin
            sticky_cy_d = 1'b0;
            sticky_v_d  = 1'b0;
            ovf_count_d = '0;
        end else if (accept) begin
            sticky_cy_d = sticky_cy_q || in_cy;
            sticky_v_d  = sticky_v_q || in_v;
            if (in_v && (ovf_count_q != CNT_MAX)) begin
                ovf_count_d = ovf_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            z_q         <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            sticky_cy_q <= 1'b0;
            sticky_v_q  <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            sticky_cy_q <= sticky_cy_d;
            sticky_v_q  <= sticky_v_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    logic f_s, f_zr, f_cy, f_p, f_v;
    logic cond_raw;

    assign {f_s, f_zr, f_cy, f_p, f_v} = flags_q;

    always_comb begin
        cond_raw = 1'b0;
        case (cond_sel)
            4'h0: cond_raw = f_zr;
            4'h1: cond_raw = !f_zr;
            4'h2: cond_raw = f_cy;
            4'h3: cond_raw = !f_cy;
            4'h4: cond_raw = f_s;
            4'h5: cond_raw = !f_s;
            4'h6: cond_raw = f_v;
            4'h7: cond_raw = !f_v;
            4'h8: cond_raw = f_cy && !f_zr;
            4'h9: cond_raw = !f_cy || f_zr;
            4'hA: cond_raw = (f_s == f_v);
            4'hB: cond_raw = (f_s != f_v);
            4'hC: cond_raw = !f_zr && (f_s == f_v);
            4'hD: cond_raw = f_zr || (f_s != f_v);
            4'hE: cond_raw = f_p;
            default: cond_raw = 1'b1;
        endcase
    end

    assign cond_true = out_valid_q && cond_raw;

    assign out_valid = out_valid_q;
    assign out_z     = z_q;
    assign out_flags = flags_q;
    assign flag_err  = err_q;
    assign sticky_cy = sticky_cy_q;
    assign sticky_v  = sticky_v_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_adder_flag_register.sv
// Directed bench for adder_flag_register: reset, single beats, backpressure, fault detection,
// counter saturation with clear, and an 8-beat stream checked against an expected queue.
module tb_adder_flag_register;

    localparam int W     = 16;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_z;
    logic             in_s, in_zr, in_cy, in_p, in_v;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_z;
    logic [4:0]       out_flags;
    logic             flag_err;
    logic [3:0]       cond_sel;
    logic             cond_true;
    logic             clr_sticky;
    logic             sticky_cy;
    logic             sticky_v;
    logic [CNT_W-1:0] ovf_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    adder_flag_register #(.WIDTH(W), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_z       (in_z),
        .in_s       (in_s),
        .in_zr      (in_zr),
        .in_cy      (in_cy),
        .in_p       (in_p),
        .in_v       (in_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_flags  (out_flags),
        .flag_err   (flag_err),
        .cond_sel   (cond_sel),
        .cond_true  (cond_true),
        .clr_sticky (clr_sticky),
        .sticky_cy  (sticky_cy),
        .sticky_v   (sticky_v),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a beat on the input (flags as {S,ZR,CY,P,V}); caller sits just after a negedge.
    task automatic set_beat(input logic [W-1:0] z, input logic [4:0] f);
        in_valid = 1'b1;
        in_z     = z;
        {in_s, in_zr, in_cy, in_p, in_v} = f;
    endtask

    // Drive one beat for one edge, then drop in_valid; outputs are sampled after return.
    task automatic send_beat(input logic [W-1:0] z, input logic [4:0] f);
        set_beat(z, f);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_z       = '0;
        {in_s, in_zr, in_cy, in_p, in_v} = 5'b0;
        out_ready  = 1'b1;
        cond_sel   = 4'h0;
        clr_sticky = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a beat is held under backpressure
        out_ready = 1'b0;
        send_beat(16'h1234, 5'b00010);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_cnt",   32'(ovf_count), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_flags", 32'(out_flags), 32'd0);
        check("arst_out_z",     32'(out_z),     32'd0);
        check("arst_sticky_cy", 32'(sticky_cy), 32'd0);
        check("arst_sticky_v",  32'(sticky_v),  32'd0);
        check("arst_ovf_count", 32'(ovf_count), 32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Single beat, 0FFF has twelve ones so P=0
        send_beat(16'h0FFF, 5'b00101);
        check("b1_out_z",     32'(out_z),     32'h0FFF);
        check("b1_out_flags", 32'(out_flags), 32'b00101);
        check("b1_flag_err",  32'(flag_err),  32'd0);
        check("b1_sticky_cy", 32'(sticky_cy), 32'd1);
        check("b1_sticky_v",  32'(sticky_v),  32'd1);
        check("b1_ovf_count", 32'(ovf_count), 32'd1);
        cond_sel = 4'h6; #1;
        check("b1_cond_vs", 32'(cond_true), 32'd1);
        cond_sel = 4'hA; #1;
        check("b1_cond_ge", 32'(cond_true), 32'd0);

        // Backpressure: beat waits while out_ready=0
        out_ready = 1'b0;
        set_beat(16'h0000, 5'b01100);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp_hold_z",     32'(out_z),     32'h0FFF);
        check("bp_hold_flags", 32'(out_flags), 32'b00101);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_cnt",   32'(ovf_count), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cond_sel = 4'h0; #1;
        check("bp_out_z",     32'(out_z),     32'h0000);
        check("bp_out_flags", 32'(out_flags), 32'b01100);
        check("bp_cond_eq",   32'(cond_true), 32'd1);
        @(negedge clk);
        cond_sel = 4'hF; #1;
        check("idle_valid",   32'(out_valid), 32'd0);
        check("idle_cond_al", 32'(cond_true), 32'd0);

        // Flag consistency checks
        send_beat(16'hFFFF, 5'b00000);
        check("err_s_mismatch", 32'(flag_err), 32'd1);
        send_beat(16'hFFFF, 5'b10000);
        check("err_clean", 32'(flag_err), 32'd0);
        send_beat(16'h0000, 5'b00000);
        check("err_zr_mismatch", 32'(flag_err), 32'd1);
        send_beat(16'h0001, 5'b00000);
        check("err_p_mismatch", 32'(flag_err), 32'd1);

        // Clear without a beat, then saturate a 2-bit counter
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check("clr_cnt",       32'(ovf_count), 32'd0);
        check("clr_sticky_cy", 32'(sticky_cy), 32'd0);
        check("clr_sticky_v",  32'(sticky_v),  32'd0);
        for (int i = 0; i < 5; i++) begin
            send_beat(16'h0001, 5'b00111);
        end
        check("sat_cnt", 32'(ovf_count), 32'd3);
        send_beat(16'h0001, 5'b00111);
        check("sat_hold", 32'(ovf_count), 32'd3);
        clr_sticky = 1'b1;
        send_beat(16'h0001, 5'b00011);
        clr_sticky = 1'b0;
        check("clr_beat_cnt", 32'(ovf_count), 32'd1);
        check("clr_beat_v",   32'(sticky_v),  32'd1);
        check("clr_beat_cy",  32'(sticky_cy), 32'd0);

        // Streaming 8 back-to-back beats with self-consistent flags
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] z;
            z = W'(16'h0100 * i + 16'h8000 * (i % 2) + i);
            set_beat(z, {z[W-1], (z == '0), 1'b0, ^z, 1'b0});
            exp_q.push_back(z);
            #1;
            check($sformatf("st_in_ready_%0d", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            check($sformatf("st_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("st_z_%0d", i), 32'(out_z), 32'(exp_q.pop_front()));
            check($sformatf("st_err_%0d", i), 32'(flag_err), 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("st_drain_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
